// File: rtl/minimax_membus_pkg.sv
// Shared types and constants for the minimax memory-bus bridge.
// Holds the RMW FSM state enum, RAM geometry, exit-register default address
// and the byte-merge helper used by the read-modify-write path.
package minimax_membus_pkg;

  localparam int unsigned RAM_BYTES  = 8192;
  localparam int unsigned BANK_WORDS = 512;
  localparam int unsigned NBANKS     = 4;
  localparam int unsigned BANK_AW    = $clog2(BANK_WORDS);  // word address within a bank
  localparam int unsigned BANK_IW    = $clog2(NBANKS);      // bank index width
  localparam int unsigned RAM_AW     = $clog2(RAM_BYTES);   // byte address width of RAM
  localparam int unsigned WORD_AW    = RAM_AW - 2;          // {bank, word} address width

  localparam logic [31:0] EXIT_ADDR_DFLT = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RMW_RD = 2'd1,
    RMW_WR = 2'd2
  } rmw_state_e;

  // Byte i comes from new_word where mask[i] is set, otherwise from old_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/minimax_membus_rmw.sv
// Read-modify-write sequencer for sub-word stores.
// Latches the store word address, data and mask, then walks RMW_RD -> RMW_WR.
// Ports: clk, reset_n (async active-low); start_i launches a sequence from
// IDLE; word_i/wdata_i/wmask_i are the store to latch; rword_i is the bank
// read word; busy_o (Moore, non-IDLE), wen_o (write strobe in RMW_WR),
// word_o (latched word address), wdata_o (merged write word).
// Only instantiated when MINIMAX_MEMBUS_RMW_EN is defined.
module minimax_membus_rmw
  import minimax_membus_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_i,
  input  logic [WORD_AW-1:0] word_i,
  input  logic [31:0]        wdata_i,
  input  logic [3:0]         wmask_i,
  input  logic [31:0]        rword_i,
  output logic               busy_o,
  output logic               wen_o,
  output logic [WORD_AW-1:0] word_o,
  output logic [31:0]        wdata_o
);

  rmw_state_e         state_q, state_d;
  logic [WORD_AW-1:0] word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         mask_q, mask_d;

  // State and store latches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
    end
  end

  // Next state; the core holds its request while stalled, so only IDLE latches.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RMW_RD;
          word_d  = word_i;
          wdata_d = wdata_i;
          mask_d  = wmask_i;
        end
      end
      RMW_RD:  state_d = RMW_WR;
      RMW_WR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs: an async reset clears them without a clock edge.
  assign busy_o  = (state_q != IDLE);
  assign wen_o   = (state_q == RMW_WR);
  assign word_o  = word_q;
  assign wdata_o = byte_merge(rword_i, wdata_q, mask_q);

endmodule

// File: rtl/minimax_membus.sv
// Memory-bus bridge between the minimax core and four 512x32 SRAM banks.
// Data accesses win over fetch; read data and the fetched halfword are
// registered; sub-word stores become a stalled read-modify-write when
// MINIMAX_MEMBUS_RMW_EN is defined (otherwise they are dropped and stall=0).
// A full-word store to EXIT_ADDR latches a sticky halt flag and code.
// Ports: clk, reset_n (async active-low); inst_addr/inst/inst_regce fetch;
// addr/wdata/wmask/rreq/rdata/stall core data port; bank_en/bank_addr/
// bank_wdata/bank_wen/bank_rdata SRAM side (banks clocked on ~clk);
// halt/halt_code exit register.
module minimax_membus
  import minimax_membus_pkg::*;
#(
  parameter int unsigned PC_BITS   = 13,
  parameter logic [31:0] EXIT_ADDR = EXIT_ADDR_DFLT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PC_BITS-1:0]    inst_addr,
  output logic [15:0]           inst,
  input  logic                  inst_regce,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wmask,
  input  logic                  rreq,
  output logic [31:0]           rdata,
  output logic                  stall,
  output logic [NBANKS-1:0]     bank_en,
  output logic [BANK_AW-1:0]    bank_addr,
  output logic [31:0]           bank_wdata,
  output logic                  bank_wen,
  input  logic [32*NBANKS-1:0]  bank_rdata,
  output logic                  halt,
  output logic [31:0]           halt_code
);

  logic               busy, rmw_wen;
  logic [WORD_AW-1:0] rmw_word;
  logic [31:0]        rmw_wdata;
  logic               data_cycle, ram_hit, full_store;
  logic [RAM_AW-1:0]  fetch_addr;
  logic [WORD_AW-1:0] mux_word;
  logic [BANK_IW-1:0] sel_q;
  logic               zero_q;
  logic [31:0]        bank_word, rword;
  logic [15:0]        inst_lat_q, inst_q;
  logic [31:0]        rdata_q, halt_code_q;
  logic               halt_q;
  logic               unused_bits;

  assign fetch_addr  = RAM_AW'(inst_addr);
  assign data_cycle  = !busy && (rreq || (wmask != 4'h0));
  assign ram_hit     = (addr[31:RAM_AW] == '0);
  assign full_store  = (wmask == 4'hF);
  assign unused_bits = ^{addr[1:0], fetch_addr[1:0]};

`ifdef MINIMAX_MEMBUS_RMW_EN
  logic rmw_start;
  assign rmw_start = data_cycle && ram_hit && !full_store && (wmask != 4'h0);

  minimax_membus_rmw u_rmw (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (rmw_start),
    .word_i  (addr[RAM_AW-1:2]),
    .wdata_i (wdata),
    .wmask_i (wmask),
    .rword_i (bank_word),
    .busy_o  (busy),
    .wen_o   (rmw_wen),
    .word_o  (rmw_word),
    .wdata_o (rmw_wdata)
  );
`else
  assign busy      = 1'b0;
  assign rmw_wen   = 1'b0;
  assign rmw_word  = '0;
  assign rmw_wdata = '0;
`endif

  // Bank address source: latched store during RMW, else data over fetch.
  always_comb begin
    if (busy)            mux_word = rmw_word;
    else if (data_cycle) mux_word = addr[RAM_AW-1:2];
    else                 mux_word = fetch_addr[RAM_AW-1:2];
  end

  // One-hot bank select; unmapped data accesses touch no bank.
  always_comb begin
    bank_en = '0;
    for (int b = 0; b < NBANKS; b++) begin
      bank_en[b] = (mux_word[WORD_AW-1:BANK_AW] == BANK_IW'(b)) && !(data_cycle && !ram_hit);
    end
  end

  assign bank_addr  = mux_word[BANK_AW-1:0];
  assign bank_wen   = (data_cycle && full_store && ram_hit) || rmw_wen;
  assign bank_wdata = busy ? rmw_wdata : wdata;
  assign stall      = busy;

  // Bank index and unmapped flag captured alongside the banks' own ~clk read.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      sel_q  <= mux_word[WORD_AW-1:BANK_AW];
      zero_q <= data_cycle && !ram_hit;
    end
  end

  // Read mux over the banks.
  always_comb begin
    bank_word = '0;
    for (int b = 0; b < NBANKS; b++) begin
      if (sel_q == BANK_IW'(b)) bank_word = bank_rdata[32*b +: 32];
    end
  end

  assign rword = zero_q ? 32'h0 : bank_word;

  // Output registers and the sticky exit register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inst_lat_q  <= '0;
      inst_q      <= '0;
      rdata_q     <= '0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
    end else begin
      rdata_q <= rword;
      if (!busy) inst_lat_q <= inst_addr[1] ? rword[31:16] : rword[15:0];
      if (inst_regce) inst_q <= inst_lat_q;
      if (data_cycle && full_store && (addr == EXIT_ADDR) && !halt_q) begin
        halt_q      <= 1'b1;
        halt_code_q <= wdata;
      end
    end
  end

  assign inst      = inst_q;
  assign rdata     = rdata_q;
  assign halt      = halt_q;
  assign halt_code = halt_code_q;

endmodule

// File: tb/tb_minimax_membus.sv
// Self-checking bench for minimax_membus: SRAM bank model on ~clk, a
// word-array reference model of memory and the exit register, and a
// scoreboard monitor that checks rdata/inst whenever the core-side
// handshake says a result is due.
`timescale 1ns/1ps
module tb_minimax_membus;

  localparam logic [31:0] EXIT = 32'hFFFF_FFFC;
`ifdef MINIMAX_MEMBUS_RMW_EN
  localparam bit RMW_EN = 1'b1;
`else
  localparam bit RMW_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [12:0]  inst_addr = '0;
  logic [15:0]  inst;
  logic         inst_regce = 1'b0;
  logic [31:0]  addr = '0;
  logic [31:0]  wdata = '0;
  logic [3:0]   wmask = '0;
  logic         rreq = 1'b0;
  logic [31:0]  rdata;
  logic         stall;
  logic [3:0]   bank_en;
  logic [8:0]   bank_addr;
  logic [31:0]  bank_wdata;
  logic         bank_wen;
  logic [127:0] bank_rdata = '0;
  logic         halt;
  logic [31:0]  halt_code;

  minimax_membus dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .inst_addr  (inst_addr),
    .inst       (inst),
    .inst_regce (inst_regce),
    .addr       (addr),
    .wdata      (wdata),
    .wmask      (wmask),
    .rreq       (rreq),
    .rdata      (rdata),
    .stall      (stall),
    .bank_en    (bank_en),
    .bank_addr  (bank_addr),
    .bank_wdata (bank_wdata),
    .bank_wen   (bank_wen),
    .bank_rdata (bank_rdata),
    .halt       (halt),
    .halt_code  (halt_code)
  );

  always #5 clk = ~clk;

  // SRAM banks: read-first, clocked on the falling edge.
  logic [31:0] bank_mem [4][512];
  always @(negedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bank_en[b]) begin
        logic [31:0] rd;
        rd = bank_mem[b][bank_addr];
        if (bank_wen) bank_mem[b][bank_addr] = bank_wdata;
        bank_rdata[32*b +: 32] <= rd;
      end
    end
  end

  // Reference model.
  logic [31:0] ref_mem [2048];
  logic        ref_halt = 1'b0;
  logic [31:0] ref_code = '0;

  typedef struct { logic [31:0] a; logic [31:0] v; } exp_t;
  exp_t        rd_q[$];
  logic [15:0] inst_q[$];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic bit is_ram(input logic [31:0] a);
    return a < 32'h2000;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [10:0] idx;
    idx = a[12:2];
    return is_ram(a) ? ref_mem[idx] : 32'h0;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [10:0] idx;
    idx = a[12:2];
    if (m == 4'hF) begin
      if (is_ram(a)) ref_mem[idx] = d;
      else if (a == EXIT && !ref_halt) begin
        ref_halt = 1'b1;
        ref_code = d;
      end
    end else if (m != 4'h0 && is_ram(a) && RMW_EN) begin
      for (int i = 0; i < 4; i++)
        if (m[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  task automatic preload(input logic [10:0] idx, input logic [31:0] v);
    ref_mem[idx] = v;
    bank_mem[idx[10:9]][idx[8:0]] = v;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    rreq = 1'b0;
    wmask = 4'h0;
    inst_regce = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a);
    exp_t e;
    e.a = a;
    e.v = model_read(a);
    rd_q.push_back(e);
    rreq = 1'b1; addr = a; wmask = 4'h0; inst_regce = 1'b0; wdata = $urandom;
    #1 chk("read stall", 32'(stall), 32'h0);
    cyc();
    rreq = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [3:0]  exp_en;
    logic        exp_wen;
    int          exp_n, n;
    logic [10:0] idx;
    idx     = a[12:2];
    exp_en  = is_ram(a) ? (4'b0001 << a[12:11]) : 4'b0000;
    exp_wen = is_ram(a) && (m == 4'hF);
    exp_n   = (RMW_EN && is_ram(a) && m != 4'h0 && m != 4'hF) ? 2 : 0;
    rreq = 1'b0; addr = a; wdata = d; wmask = m; inst_regce = 1'b0;
    #1;
    chk("store bank_en", 32'(bank_en), 32'(exp_en));
    chk("store bank_addr", 32'(bank_addr), 32'(idx[8:0]));
    chk("store bank_wen", 32'(bank_wen), 32'(exp_wen));
    model_store(a, d, m);
    cyc();
    n = 0;
    while (stall && n < 8) begin
      n++;
      if (n == 2) begin
        chk("rmw bank_wen", 32'(bank_wen), 32'h1);
        chk("rmw merged word", bank_wdata, ref_mem[idx]);
      end
      cyc();
    end
    chk("store stall cycles", n, exp_n);
    wmask = 4'h0;
  endtask

  task automatic do_fetch(input logic [12:0] a);
    logic [10:0] idx;
    logic [31:0] w;
    idx = a[12:2];
    w = ref_mem[idx];
    drive_idle();
    inst_addr = a;
    cyc();
    inst_q.push_back(a[1] ? w[31:16] : w[15:0]);
    inst_regce = 1'b1;
    cyc();
    inst_regce = 1'b0;
  endtask

  // Scoreboard monitor: a result is due after any edge that accepted rreq or inst_regce.
  initial begin
    logic acc, fet;
    exp_t e;
    logic [15:0] ei;
    forever begin
      @(negedge clk);
      acc = reset_n && rreq && !stall;
      fet = reset_n && inst_regce;
      @(posedge clk);
      #1;
      if (acc) begin
        if (rd_q.size() == 0) chk("rdata queue underflow", 32'h1, 32'h0);
        else begin
          e = rd_q.pop_front();
          chk($sformatf("rdata @%h", e.a), rdata, e.v);
        end
      end
      if (fet) begin
        if (inst_q.size() == 0) chk("inst queue underflow", 32'h1, 32'h0);
        else begin
          ei = inst_q.pop_front();
          chk("inst", 32'(inst), 32'(ei));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          k;
    logic [10:0] idx;
    logic [31:0] a;
    logic [3:0]  m;
    logic        hb;

    for (int i = 0; i < 2048; i++) preload(11'(i), $urandom);

    // Reset values.
    cyc(); cyc();
    chk("reset rdata", rdata, 32'h0);
    chk("reset inst", 32'(inst), 32'h0);
    chk("reset stall", 32'(stall), 32'h0);
    chk("reset bank_wen", 32'(bank_wen), 32'h0);
    chk("reset halt", 32'(halt), 32'h0);
    chk("reset halt_code", halt_code, 32'h0);
    reset_n = 1'b1;
    cyc();

    // Directed cases.
    preload(11'h40, 32'h1122_3344);
    do_read(32'h100);
    preload(11'h40, 32'hAABB_CCDD);
    do_fetch(13'h102);
    preload(11'h40, 32'h1122_3344);
    do_store(32'h100, 32'h0000_EE00, 4'b0010);
    do_read(32'h100);
    do_store(32'h1FFC, 32'hDEAD_BEEF, 4'hF);
    do_read(32'h1FFC);
    do_read(32'h0000_4000);
    do_store(EXIT, 32'h0, 4'hF);
    do_store(EXIT, 32'h5, 4'hF);
    do_store(EXIT, 32'h12, 4'b0001);
    chk("halt after exit writes", 32'(halt), 32'h1);
    chk("halt_code first write wins", halt_code, 32'h0);

    // Reset in the middle of a read-modify-write.
    preload(11'h50, 32'hCAFE_F00D);
    rreq = 1'b0; addr = 32'h140; wdata = 32'h7777_7777; wmask = 4'b0100;
    cyc();
    chk("rmw_rd stall", 32'(stall), 32'(RMW_EN));
    reset_n = 1'b0;
    #1;
    chk("reset mid-rmw stall", 32'(stall), 32'h0);
    chk("reset mid-rmw bank_wen", 32'(bank_wen), 32'h0);
    chk("reset clears halt", 32'(halt), 32'h0);
    chk("reset clears halt_code", halt_code, 32'h0);
    ref_halt = 1'b0;
    ref_code = '0;
    drive_idle();
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    do_read(32'h140);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      k   = $urandom_range(0, 9);
      idx = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(0, 7)) : 11'($urandom_range(0, 2047));
      a   = {19'h0, idx, 2'b00};
      case (k)
        0, 1, 2: do_read(a);
        3:       do_read(($urandom | 32'h0001_0000) & 32'hFFFF_FFFC);
        4:       do_store(a, $urandom, 4'hF);
        5, 6: begin
          m = 4'($urandom_range(1, 14));
          do_store(a, $urandom, m);
        end
        7: begin
          m = 4'($urandom_range(1, 15));
          a = ($urandom_range(0, 3) == 0) ? EXIT : (($urandom | 32'h0000_2000) & 32'hFFFF_FFFC);
          do_store(a, $urandom, m);
        end
        8: begin
          hb = 1'($urandom_range(0, 1));
          do_fetch({idx, hb, 1'b0});
        end
        default: begin
          drive_idle();
          cyc();
        end
      endcase
    end

    drive_idle();
    repeat (3) cyc();
    chk("rdata queue drained", rd_q.size(), 32'h0);
    chk("inst queue drained", inst_q.size(), 32'h0);
    chk("final halt", 32'(halt), 32'(ref_halt));
    chk("final halt_code", halt_code, ref_code);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/minimax_membus.md
# minimax_membus

Memory-bus bridge between the minimax core and the four 512x32 SRAM banks (8 kB, byte addresses 0x0000-0x1FFF). It arbitrates data accesses over instruction fetch and registers the returned read data and instruction halfword. It turns sub-word stores into a stalled read-modify-write (RMW), because the banks only support full-word writes. It also decodes the simulation/test exit register at 0xFFFFFFFC.

## Interface
Parameters:
- PC_BITS, 13: width of the core instruction address.
- EXIT_ADDR, 32'hFFFFFFFC: exit/halt register address.

Ports:
- clk  in  1: single clock; banks are clocked on ~clk externally.
- reset_n  in  1: asynchronous, active-low reset.
- inst_addr  in  PC_BITS: core fetch byte address.
- inst  out  16: registered instruction halfword to the core.
- inst_regce  in  1: load enable for `inst`.
- addr  in  32: core data byte address.
- wdata  in  32: core store data, byte lanes already aligned.
- wmask  in  4: store byte enables; 0 means no store.
- rreq  in  1: core data read request.
- rdata  out  32: registered data read word.
- stall  out  1: core must hold its request while high.
- bank_en  out  4: one-hot bank select, from addr[12:11].
- bank_addr  out  9: word address within the bank, addr[10:2].
- bank_wdata  out  32: write word to the banks.
- bank_wen  out  1: full-word write strobe.
- bank_rdata  in  128: bank 3..0 read words, concatenated with bank 0 in bits [31:0].
- halt  out  1: sticky flag, exit register written.
- halt_code  out  32: value written to the exit register.

## Operation
- Address mux (combinational):
  - In IDLE, a data cycle is any cycle with rreq=1 or wmask≠0.
  - In a data cycle the bank address comes from addr; otherwise it comes from inst_addr.
  - In RMW states the bank address comes from the latched store address.
- RAM region: addr[31:13]==0. Data accesses outside the RAM region drive bank_en=0.
- Read mux: the read word is the bank_rdata slice selected by the *registered* bank index.
- Registered paths (every clk edge):
  - inst_lat <= the inst_addr[1] ? upper : lower halfword of the read word.
  - rdata <= read word.
  - inst <= inst_lat when inst_regce=1.
- Full-word store (wmask=4'hF) to RAM: bank_wen=1 in the same cycle, no stall.
- Sub-word store to RAM runs the FSM:
  - IDLE -> RMW_RD: latch addr, wdata and wmask; read the target word; stall=1.
  - RMW_RD -> RMW_WR: merge, taking byte i from the latched wdata when mask[i]=1, else from the read word; bank_wen=1; stall=1.
  - RMW_WR -> IDLE: stall=0.
- Exit register: a full-word store to EXIT_ADDR sets halt=1 and halt_code=wdata. The first write wins; later writes are ignored.
- Other accesses outside the RAM region:
  - Stores are dropped.
  - Reads return 0.
  - None of them stall.
- Fetch during RMW: fetch is suppressed and inst_lat holds its value.

## Timing
- Reset values: inst=0, rdata=0, stall=0, bank_wen=0, halt=0, halt_code=0, FSM=IDLE.
- Read latency: address presented in cycle N; data is valid on rdata/inst_lat after the clk edge that ends cycle N.
- Full-word store: 1 cycle, no stall.
- Sub-word store: stall is high for exactly 2 cycles, and the write commits in the second.
- stall is a Moore output of the FSM. The core samples it and holds addr, wdata and wmask; the bridge uses its latched copies regardless.
- Reset asserted mid-RMW: the FSM returns to IDLE immediately, bank_wen drops with no clock edge, and the partial write is discarded.
- Sub-word store to EXIT_ADDR or to an unmapped address: dropped, no RMW, no stall.
- Back-to-back sub-word stores: the second is accepted in the cycle after RMW_WR, when the FSM is IDLE again.

## Configuration
- MINIMAX_MEMBUS_RMW_EN defined: sub-word stores perform the RMW sequence above.
- MINIMAX_MEMBUS_RMW_EN undefined:
  - The FSM is removed and stall is tied to 0.
  - Sub-word stores to RAM are dropped (bank_wen=0).
  - Full-word stores and reads are unchanged.

## Structure
- minimax_membus_pkg holds:
  - the FSM state enum (IDLE, RMW_RD, RMW_WR);
  - EXIT_ADDR default, RAM_BYTES=8192, BANK_WORDS=512, NBANKS=4;
  - a byte-merge function.
- Sub-module minimax_membus_rmw contains the FSM, the address/data/mask latches and the merge. The top level keeps the address mux, bank decode, read mux, output registers and the exit register.

## Test plan
- Preload word 0x100 with 0x11223344; assert rreq with addr=0x100 -> rdata=0x11223344 one cycle later, stall stays 0.
- Fetch with inst_addr=0x102 and inst_regce=1, word 0x100 = 0xAABBCCDD -> inst=0xAABB after two edges.
- Store wmask=4'b0010, wdata=0x0000EE00 to 0x100, word holding 0x11223344 -> stall high for exactly 2 cycles, then a read returns 0x1122EE44. Without MINIMAX_MEMBUS_RMW_EN the read returns 0x11223344 and stall stays 0.
- Full-word store 0xDEADBEEF to 0x1FFC (bank 3, last word) -> bank_en=4'b1000, bank_addr=511, readback 0xDEADBEEF.
- Store 0 to 0xFFFFFFFC, then 5 -> halt=1, halt_code=0 (the first write wins).
- Pull reset_n low during RMW_RD -> stall=0 and bank_wen=0 immediately; memory is unchanged after release.
